lcd_sequencer: RTL and testbench

LCD_SEQUENCER -- requirements
Module: lcd_sequencer

---
 rtl/lcd_pkg.sv | 39 +++
 rtl/lcd_req_fifo.sv | 61 ++++++
 rtl/lcd_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_lcd_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared definitions for the LCD sequencer. Holds the FSM state
//               encodings, the opcodes that need the long busy wait, and the
//               power-on init command table with its lookup helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE       = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_SETUP      = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_PULSE      = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_HOLD       = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_WAIT       = 3'd4;
    localparam logic [c_STATE_W-1:0] c_ST_INIT_WAIT  = 3'd5;
    localparam logic [c_STATE_W-1:0] c_ST_INIT_ISSUE = 3'd6;

    // Clear display and return home are the slow controller commands.
    localparam logic [7:0] c_CMD_CLEAR = 8'h01;
    localparam logic [7:0] c_CMD_HOME  = 8'h02;

    // Init table, entry 0 in the low byte: function set, display on,
    // entry mode, clear.
    localparam logic [31:0] c_INIT_CMDS = {8'h01, 8'h06, 8'h0C, 8'h38};
    localparam logic [1:0]  c_INIT_LAST = 2'd3;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        return c_INIT_CMDS[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == c_CMD_CLEAR) || (data == c_CMD_HOME));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lcd_req_fifo
// Description : Synchronous request FIFO with registered storage and
//               full/empty flags. Read data is the current head entry
//               (first-word fall-through). Writes when full and reads when
//               empty are ignored.
// Ports       : clk, rst_n (async active-low)
//               i_wr_en, i_wr_data  - push side
//               i_rd_en, o_rd_data  - pop side, o_rd_data is the head
//               o_full, o_empty     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [c_ADDR_W:0] r_wr_ptr;
    logic [c_ADDR_W:0] r_rd_ptr;
    logic              w_push;
    logic              w_pop;

    assign w_push = i_wr_en && !o_full;
    assign w_pop  = i_rd_en && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr[c_ADDR_W-1:0]];
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                       (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);

endmodule
`default_nettype wire

// File: rtl/lcd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_sequencer
// Description : Queues LCD command/data bytes and plays each one out on an
//               HD44780-style bus: SETUP, enable PULSE, HOLD, then a busy
//               WAIT whose length depends on the command. Clear/home
//               commands (RS=0, 0x01/0x02) get the long wait.
//               Build macro LCD_INIT_SEQ_EN adds a power-on delay followed by
//               the standard init command sequence before requests are served.
// Ports       : clk, rst_n (async active-low)
//               req_valid/req_ready/req_rs/req_data - request push interface
//               busy       - transfer in progress or queue non-empty
//               lcd_data   - data byte to the panel
//               lcd_ctrl   - {rs, rw}, rw is always 0
//               lcd_enable - enable strobe
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC     = 2,
    parameter int PULSE_CYC     = 25,
    parameter int HOLD_CYC      = 2,
    parameter int CMD_WAIT_CYC  = 2000,
    parameter int CLR_WAIT_CYC  = 80000,
    parameter int INIT_WAIT_CYC = 1000000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic [7:0] lcd_data,
    output logic [1:0] lcd_ctrl,
    output logic       lcd_enable
);

`ifdef LCD_INIT_SEQ_EN
    localparam logic [c_STATE_W-1:0] c_RESET_STATE = c_ST_INIT_WAIT;
`else
    localparam logic [c_STATE_W-1:0] c_RESET_STATE = c_ST_IDLE;
`endif

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;
    logic [31:0]          r_cnt;
    logic [31:0]          w_limit;
    logic                 w_cnt_done;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [8:0]           w_fifo_rd;

    logic                 r_rs;
    logic [7:0]           r_data;
    logic                 r_long_wait;
    logic                 w_load;
    logic                 w_load_rs;
    logic [7:0]           w_load_data;

`ifdef LCD_INIT_SEQ_EN
    logic [1:0]           r_init_idx;
    logic                 r_init_busy;
`endif

    assign w_push = req_valid && !w_full;

    lcd_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_push),
        .i_wr_data ({req_rs, req_data}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_rd),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_RESET_STATE;
        else        r_state <= w_next_state;
    end

    // Length of the current timed phase.
    always_comb begin
        w_limit = 32'd1;
        case (r_state)
            c_ST_SETUP:     w_limit = 32'(SETUP_CYC);
            c_ST_PULSE:     w_limit = 32'(PULSE_CYC);
            c_ST_HOLD:      w_limit = 32'(HOLD_CYC);
            c_ST_WAIT:      w_limit = r_long_wait ? 32'(CLR_WAIT_CYC) : 32'(CMD_WAIT_CYC);
`ifdef LCD_INIT_SEQ_EN
            c_ST_INIT_WAIT: w_limit = 32'(INIT_WAIT_CYC);
`endif
            default:        w_limit = 32'd1;
        endcase
    end

    assign w_cnt_done = (r_cnt == (w_limit - 32'd1));

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:  if (!w_empty)  w_next_state = c_ST_SETUP;
            c_ST_SETUP: if (w_cnt_done) w_next_state = c_ST_PULSE;
            c_ST_PULSE: if (w_cnt_done) w_next_state = c_ST_HOLD;
            c_ST_HOLD:  if (w_cnt_done) w_next_state = c_ST_WAIT;
            c_ST_WAIT: begin
                if (w_cnt_done) begin
`ifdef LCD_INIT_SEQ_EN
                    if (r_init_busy && (r_init_idx != c_INIT_LAST))
                        w_next_state = c_ST_INIT_ISSUE;
                    else
                        w_next_state = c_ST_IDLE;
`else
                    w_next_state = c_ST_IDLE;
`endif
                end
            end
`ifdef LCD_INIT_SEQ_EN
            c_ST_INIT_WAIT:  if (w_cnt_done) w_next_state = c_ST_INIT_ISSUE;
            c_ST_INIT_ISSUE: w_next_state = c_ST_SETUP;
`endif
            default: w_next_state = c_RESET_STATE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_load_rs   = r_rs;
        w_load_data = r_data;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_load_rs   = w_fifo_rd[8];
                    w_load_data = w_fifo_rd[7:0];
                end
            end
`ifdef LCD_INIT_SEQ_EN
            c_ST_INIT_ISSUE: begin
                w_load      = 1'b1;
                w_load_rs   = 1'b0;
                w_load_data = init_cmd(r_init_idx);
            end
`endif
            default: ;
        endcase
        // Enable derives straight from the state so an async reset drops it
        // immediately.
        lcd_enable = (r_state == c_ST_PULSE);
        busy       = (r_state != c_ST_IDLE) || !w_empty;
        req_ready  = !w_full;
        lcd_data   = r_data;
        lcd_ctrl   = {r_rs, 1'b0};
    end

    // ---------------- phase counter and bus registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
            r_long_wait <= 1'b0;
        end else begin
            // Restart on every state change; hold at zero while idle.
            if ((r_state != w_next_state) || (r_state == c_ST_IDLE))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 32'd1;
            if (w_load) begin
                r_rs        <= w_load_rs;
                r_data      <= w_load_data;
                r_long_wait <= is_long_cmd(w_load_rs, w_load_data);
            end
        end
    end

`ifdef LCD_INIT_SEQ_EN
    // Tracks which init command is in flight; cleared once the last one
    // finishes its wait so normal requests start being served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_idx  <= 2'd0;
            r_init_busy <= 1'b1;
        end else if (r_init_busy && (r_state == c_ST_WAIT) && w_cnt_done) begin
            if (r_init_idx == c_INIT_LAST) r_init_busy <= 1'b0;
            else                           r_init_idx  <= r_init_idx + 2'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_sequencer
// Description : Directed self-checking bench for lcd_sequencer with short
//               timing parameters. A monitor records the byte, control and
//               cycle number at every rising edge of lcd_enable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_sequencer;

    localparam int SETUP  = 1;
    localparam int PULSE  = 3;
    localparam int HOLD   = 1;
    localparam int CMD_W  = 4;
    localparam int CLR_W  = 10;
    localparam int INIT_W = 5;
`ifdef LCD_INIT_SEQ_EN
    localparam logic c_INIT_EN = 1'b1;
`else
    localparam logic c_INIT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready;
    logic       busy;
    logic [7:0] lcd_data;
    logic [1:0] lcd_ctrl;
    logic       lcd_enable;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] cap_data[$];
    logic [1:0] cap_ctrl[$];
    int         cap_cyc[$];
    logic       prev_en = 1'b0;

    lcd_sequencer #(
        .SETUP_CYC     (SETUP),
        .PULSE_CYC     (PULSE),
        .HOLD_CYC      (HOLD),
        .CMD_WAIT_CYC  (CMD_W),
        .CLR_WAIT_CYC  (CLR_W),
        .INIT_WAIT_CYC (INIT_W),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rs     (req_rs),
        .req_data   (req_data),
        .busy       (busy),
        .lcd_data   (lcd_data),
        .lcd_ctrl   (lcd_ctrl),
        .lcd_enable (lcd_enable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (lcd_enable && !prev_en) begin
            cap_data.push_back(lcd_data);
            cap_ctrl.push_back(lcd_ctrl);
            cap_cyc.push_back(cyc);
        end
        prev_en = lcd_enable;
    end

    // Bounded wait for busy to drop; a timeout counts as a failure.
    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, want 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++; if (busy !== c_INIT_EN) begin errors++; $display("FAIL reset_busy: got %b want %b", busy, c_INIT_EN); end
        checks++; if (lcd_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", lcd_enable); end
        checks++; if (lcd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", lcd_data); end
        checks++; if (lcd_ctrl !== 2'b00) begin errors++; $display("FAIL reset_ctrl: got %b want 00", lcd_ctrl); end
        rst_n = 1'b1;
        wait_idle("reset", 400);
    endtask

    // One request from IDLE: 1 cycle queued in IDLE, then SETUP, PULSE,
    // HOLD, WAIT, then IDLE with busy low.
    task automatic test_single(input string name, input logic rs, input logic [7:0] d, input int wlen);
        int bad;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b want 1", name, req_ready); end
        req_valid = 1'b1; req_rs = rs; req_data = d;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1 || lcd_enable !== 1'b0) begin errors++; $display("FAIL %s_queued: busy=%b en=%b want busy=1 en=0", name, busy, lcd_enable); end
        @(negedge clk);
        checks++; if ({lcd_ctrl, lcd_data} !== {rs, 1'b0, d}) begin errors++; $display("FAIL %s_bus: got ctrl=%b data=%h want ctrl=%b0 data=%h", name, lcd_ctrl, lcd_data, rs, d); end
        checks++; if (lcd_enable !== 1'b0) begin errors++; $display("FAIL %s_setup_en: got %b want 0", name, lcd_enable); end
        bad = 0;
        for (int i = 0; i < PULSE + HOLD + wlen; i++) begin
            @(negedge clk);
            if (lcd_enable !== ((i < PULSE) ? 1'b1 : 1'b0)) bad++;
            if (busy !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL %s_timing: %0d bad enable/busy samples, want 0", name, bad); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_end_busy: got %b want 0", name, busy); end
        checks++; if ({lcd_ctrl, lcd_data} !== {rs, 1'b0, d}) begin errors++; $display("FAIL %s_hold_bus: got ctrl=%b data=%h want ctrl=%b0 data=%h", name, lcd_ctrl, lcd_data, rs, d); end
    endtask

    task automatic test_back_to_back();
        int bad;
        logic [7:0] exp_d;
        cap_data.delete(); cap_ctrl.delete(); cap_cyc.delete();
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_push%0d: got %b want 1", i, req_ready); end
            req_valid = 1'b1; req_rs = 1'b1; req_data = 8'hA0 + 8'(i);
            @(negedge clk);
        end
        req_valid = 1'b0;
        // FIFO holds 4 from here until the second pop, 7 cycles later.
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            if (req_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_full_window: %0d cycles with ready=1, want 0", bad); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_pop: got %b want 1", req_ready); end
        wait_idle("b2b", 200);
        checks++; if (cap_data.size() != 5) begin errors++; $display("FAIL b2b_count: got %0d pulses want 5", cap_data.size()); end
        if (cap_data.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                exp_d = 8'hA0 + 8'(i);
                checks++; if (cap_data[i] !== exp_d || cap_ctrl[i] !== 2'b10) begin errors++; $display("FAIL b2b_entry%0d: got data=%h ctrl=%b want data=%h ctrl=10", i, cap_data[i], cap_ctrl[i], exp_d); end
            end
            for (int i = 0; i < 4; i++) begin
                checks++; if (cap_cyc[i+1] - cap_cyc[i] != 10) begin errors++; $display("FAIL b2b_spacing%0d: got %0d cycles want 10", i, cap_cyc[i+1] - cap_cyc[i]); end
            end
        end
    endtask

`ifdef LCD_INIT_SEQ_EN
    task automatic test_init();
        logic [7:0] exp_q[5];
        exp_q = '{8'h38, 8'h0C, 8'h06, 8'h01, 8'h55};
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        cap_data.delete(); cap_ctrl.delete(); cap_cyc.delete();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h55;
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle("init", 400);
        checks++; if (cap_data.size() != 5) begin errors++; $display("FAIL init_count: got %0d pulses want 5", cap_data.size()); end
        if (cap_data.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (cap_data[i] !== exp_q[i] || cap_ctrl[i] !== ((i == 4) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL init_entry%0d: got data=%h ctrl=%b want data=%h", i, cap_data[i], cap_ctrl[i], exp_q[i]); end
            end
        end
    endtask
`endif

    task automatic test_reset_mid_pulse();
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h77;
        @(negedge clk);
        req_data = 8'h78;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (lcd_enable !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++; if (lcd_enable !== 1'b1) begin errors++; $display("FAIL rstmid_pulse_timeout: en=%b want 1", lcd_enable); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        cap_data.delete(); cap_ctrl.delete(); cap_cyc.delete();
        checks++; if (lcd_enable !== 1'b0) begin errors++; $display("FAIL rstmid_enable: got %b want 0", lcd_enable); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", req_ready); end
        checks++; if (busy !== c_INIT_EN) begin errors++; $display("FAIL rstmid_busy: got %b want %b", busy, c_INIT_EN); end
        checks++; if ({lcd_ctrl, lcd_data} !== 10'h000) begin errors++; $display("FAIL rstmid_bus: got ctrl=%b data=%h want 00/00", lcd_ctrl, lcd_data); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        wait_idle("rstmid", 400);
        checks++; if (cap_data.size() != (c_INIT_EN ? 4 : 0)) begin errors++; $display("FAIL rstmid_lost: got %0d pulses want %0d", cap_data.size(), c_INIT_EN ? 4 : 0); end
    endtask

    initial begin
        test_reset();
        test_single("data41",  1'b1, 8'h41, CMD_W);
        test_single("clear",   1'b0, 8'h01, CLR_W);
        test_single("home",    1'b0, 8'h02, CLR_W);
        test_single("cmd03",   1'b0, 8'h03, CMD_W);
        test_single("cmd00",   1'b0, 8'h00, CMD_W);
        test_single("data01",  1'b1, 8'h01, CMD_W);
        test_back_to_back();
`ifdef LCD_INIT_SEQ_EN
        test_init();
`endif
        test_reset_mid_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
